sema_multi_ctrl: RTL and testbench
==================================

Name: sema_multi_ctrl

Overview:
Parametrised traffic-light (semaphore) controller for N_DIR conflicting approaches. It sequences each approach round-robin through the red, red+yellow, green, yellow, all-red cycle with programmable phase durations. It adds two features: per-approach pedestrian request latching with a walk signal, and a night mode in which all yellow lamps flash. The block sits under top and replaces the fixed two-light sequencer.

Parameters:
N_DIR, 2, number of approaches (>=2)
CNT_W, 8, phase timer width; must hold max(T_*)-1
T_ALLRED, 2, all-red clearance cycles (>=1)
T_REDYEL, 2, red+yellow cycles (>=1)
T_GREEN, 8, green cycles (>=1)
T_YELLOW, 3, yellow cycles (>=1)
T_BLINK, 4, night-mode half-period in cycles (>=1)
(derived) IDX_W = max(1, clog2(N_DIR))

Ports:
clk  in  1  system clock, rising edge
nReset  in  1  asynchronous active-low reset
en  in  1  1 = timer runs; 0 = freeze state, timer and lamps
night_mode  in  1  request flashing-yellow operation
ped_req  in  N_DIR  pedestrian request per approach, level-sampled each edge
red  out  N_DIR  red lamp per approach
yellow  out  N_DIR  yellow lamp per approach
green  out  N_DIR  green lamp per approach
ped_walk  out  N_DIR  walk signal per approach
active_dir  out  IDX_W  approach currently served
phase  out  3  0=ALL_RED 1=RED_YEL 2=GREEN 3=YELLOW 4=NIGHT

Behaviour:
- All outputs registered. Reset (async, also mid-operation):
  - phase=ALL_RED, timer=T_ALLRED-1, active_dir=0, next_dir=0.
  - red=all 1; yellow=green=ped_walk=0; pending requests cleared.
- Timer: loaded with T_x-1 on state entry and decremented each edge while en=1. A state is left on the edge where timer==0 and en=1, so each state lasts exactly T_x enabled cycles. en=0 holds everything except request latching.
- Transitions:
  - ALL_RED->RED_YEL (active_dir<=next_dir) if night_mode=0.
  - ALL_RED->NIGHT if night_mode=1.
  - RED_YEL->GREEN, GREEN->YELLOW.
  - YELLOW->ALL_RED, with next_dir<=(active_dir+1) mod N_DIR.
  - NIGHT->ALL_RED on the first enabled edge with night_mode=0; night_mode is ignored in every other state.
- Lamps for the served approach:
  - RED_YEL: red=1, yellow=1.
  - GREEN: green only.
  - YELLOW: yellow only.
  - All other approaches: red only.
  - ALL_RED: red on every approach.
  - Exactly one approach may be non-red outside NIGHT.
- NIGHT: red=green=0. Yellow is all-1 on entry and toggles every T_BLINK enabled cycles. The timer is reloaded with T_BLINK-1 at each toggle.
- Pedestrian handling:
  - pending[i] is set on any edge with ped_req[i]=1.
  - On the edge entering GREEN for approach i: ped_walk[i]<=pending[i] | ped_req[i], and pending[i] is cleared. A request on that same edge counts as served.
  - ped_walk[i] drops on the edge leaving GREEN.
  - A request raised during approach i's own GREEN is latched for the next round.
  - In NIGHT, ped_walk=0 and requests remain pending.
- Wrap-around: after approach N_DIR-1 is served, next_dir returns to 0.
- Sequence cycle length per approach: T_REDYEL+T_GREEN+T_YELLOW+T_ALLRED.

Test Plan:
1. Defaults, release reset, en=1, numbering edges from 1 after release:
   - edges 1-2: phase=0, red=11.
   - after edge 2: red=11, yellow=01.
   - after edge 4: green=01 for 8 cycles.
   - after edge 12: yellow=01.
   - after edge 15: all red.
   - after edge 17: approach 1 RED_YEL.
   - after edge 19: green=10, active_dir=1.
2. ped_req[1] pulsed 1 cycle during approach 0 green -> ped_walk=10 from edge 19 to edge 27; approach 1's next green has ped_walk=00.
3. en=0 for 5 cycles mid-GREEN -> lamps and phase frozen; green ends 5 cycles later than in scenario 1 (after edge 17 instead of 12).
4. night_mode=1 during approach 0 GREEN -> sequence completes to ALL_RED, then NIGHT:
   - red=green=00, yellow toggles 11/00 every 4 cycles.
   - Deassert -> ALL_RED for 2 cycles, then RED_YEL on approach 1.
5. nReset asserted mid-YELLOW -> outputs immediately red=all 1, active_dir=0, pending cleared; the sequence restarts as in scenario 1.
6. N_DIR=3, T_GREEN=1 -> active_dir cycles 0,1,2,0; green lasts exactly 1 cycle; never more than one approach non-red.

Source files
------------

// File: rtl/sema_multi_ctrl.sv
// Round-robin traffic-light controller for N_DIR approaches
// with pedestrian walk latching and flashing-yellow night mode.
module sema_multi_ctrl #(
  parameter int N_DIR    = 2,
  parameter int CNT_W    = 8,
  parameter int T_ALLRED = 2,
  parameter int T_REDYEL = 2,
  parameter int T_GREEN  = 8,
  parameter int T_YELLOW = 3,
  parameter int T_BLINK  = 4,
  localparam int IDX_W = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             en,
  input  logic             night_mode,
  input  logic [N_DIR-1:0] ped_req,
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] yellow,
  output logic [N_DIR-1:0] green,
  output logic [N_DIR-1:0] ped_walk,
  output logic [IDX_W-1:0] active_dir,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    S_ALLRED = 3'd0,
    S_REDYEL = 3'd1,
    S_GREEN  = 3'd2,
    S_YELLOW = 3'd3,
    S_NIGHT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] L_REDYEL = CNT_W'(T_REDYEL - 1);
  localparam logic [CNT_W-1:0] L_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] L_BLINK  = CNT_W'(T_BLINK - 1);
  localparam logic [IDX_W-1:0] L_LAST   = IDX_W'(N_DIR - 1);

  state_t           r_phase, w_phase_n;
  logic [CNT_W-1:0] r_timer, w_timer_n;
  logic [IDX_W-1:0] r_active, w_active_n;
  logic [IDX_W-1:0] r_next, w_next_n;
  logic [N_DIR-1:0] r_pending, w_pend_n;
  logic [N_DIR-1:0] r_walk, w_walk_n;
  logic             r_blink, w_blink_n;
  logic [N_DIR-1:0] r_red, w_red_n;
  logic [N_DIR-1:0] r_yel, w_yel_n;
  logic [N_DIR-1:0] r_grn, w_grn_n;
  logic             w_tz;

  assign w_tz = (r_timer == '0);

  always_comb begin
    w_phase_n  = r_phase;
    w_timer_n  = r_timer;
    w_active_n = r_active;
    w_next_n   = r_next;
    w_pend_n   = r_pending | ped_req;
    w_walk_n   = r_walk;
    w_blink_n  = r_blink;
    if (en) begin
      if (!w_tz) w_timer_n = r_timer - CNT_W'(1);
      unique case (r_phase)
        S_ALLRED: if (w_tz) begin
          if (night_mode) begin
            w_phase_n = S_NIGHT;
            w_timer_n = L_BLINK;
            w_blink_n = 1'b1;
          end else begin
            w_phase_n  = S_REDYEL;
            w_timer_n  = L_REDYEL;
            w_active_n = r_next;
          end
        end
        S_REDYEL: if (w_tz) begin
          w_phase_n = S_GREEN;
          w_timer_n = L_GREEN;
          w_walk_n  = '0;
          // a request on the entry edge itself counts as served
          w_walk_n[r_active] = r_pending[r_active] | ped_req[r_active];
          w_pend_n[r_active] = 1'b0;
        end
        S_GREEN: if (w_tz) begin
          w_phase_n = S_YELLOW;
          w_timer_n = L_YELLOW;
          w_walk_n  = '0;
        end
        S_YELLOW: if (w_tz) begin
          w_phase_n = S_ALLRED;
          w_timer_n = L_ALLRED;
          w_next_n  = (r_active == L_LAST) ? '0 : r_active + IDX_W'(1);
        end
        S_NIGHT: begin
          if (!night_mode) begin
            w_phase_n = S_ALLRED;
            w_timer_n = L_ALLRED;
          end else if (w_tz) begin
            w_timer_n = L_BLINK;
            w_blink_n = ~r_blink;
          end
        end
        default: begin
          w_phase_n = S_ALLRED;
          w_timer_n = L_ALLRED;
        end
      endcase
    end
  end

  always_comb begin
    w_red_n = '1;
    w_yel_n = '0;
    w_grn_n = '0;
    unique case (1'b1)
      (w_phase_n == S_REDYEL): w_yel_n[w_active_n] = 1'b1;
      (w_phase_n == S_GREEN): begin
        w_red_n[w_active_n] = 1'b0;
        w_grn_n[w_active_n] = 1'b1;
      end
      (w_phase_n == S_YELLOW): begin
        w_red_n[w_active_n] = 1'b0;
        w_yel_n[w_active_n] = 1'b1;
      end
      (w_phase_n == S_NIGHT): begin
        w_red_n = '0;
        w_yel_n = {N_DIR{w_blink_n}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_phase   <= S_ALLRED;
      r_timer   <= L_ALLRED;
      r_active  <= '0;
      r_next    <= '0;
      r_pending <= '0;
      r_walk    <= '0;
      r_blink   <= 1'b0;
      r_red     <= '1;
      r_yel     <= '0;
      r_grn     <= '0;
    end else begin
      r_phase   <= w_phase_n;
      r_timer   <= w_timer_n;
      r_active  <= w_active_n;
      r_next    <= w_next_n;
      r_pending <= w_pend_n;
      r_walk    <= w_walk_n;
      r_blink   <= w_blink_n;
      r_red     <= w_red_n;
      r_yel     <= w_yel_n;
      r_grn     <= w_grn_n;
    end
  end

  assign red        = r_red;
  assign yellow     = r_yel;
  assign green      = r_grn;
  assign ped_walk   = r_walk;
  assign active_dir = r_active;
  assign phase      = r_phase;

endmodule

// File: tb/tb_sema_multi_ctrl.sv
// Scoreboard bench for sema_multi_ctrl: a 2-approach and a
// 3-approach (T_GREEN=1) instance share clock and reset.
module tb_sema_multi_ctrl;

  localparam logic [2:0] P_A  = 3'd0;
  localparam logic [2:0] P_RY = 3'd1;
  localparam logic [2:0] P_G  = 3'd2;
  localparam logic [2:0] P_Y  = 3'd3;
  localparam logic [2:0] P_N  = 3'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nReset = 1'b1;
  logic en = 1'b1, night = 1'b0;
  logic [1:0] ped = '0;
  logic [1:0] red2, yel2, grn2, walk2;
  logic dir2;
  logic [2:0] ph2;

  logic en3 = 1'b1, night3 = 1'b0;
  logic [2:0] ped3 = '0;
  logic [2:0] red3, yel3, grn3, walk3;
  logic [1:0] dir3;
  logic [2:0] ph3;

  sema_multi_ctrl dut2 (
    .clk(clk), .nReset(nReset), .en(en),
    .night_mode(night), .ped_req(ped),
    .red(red2), .yellow(yel2), .green(grn2),
    .ped_walk(walk2), .active_dir(dir2), .phase(ph2)
  );

  sema_multi_ctrl #(.N_DIR(3), .T_GREEN(1)) dut3 (
    .clk(clk), .nReset(nReset), .en(en3),
    .night_mode(night3), .ped_req(ped3),
    .red(red3), .yellow(yel3), .green(grn3),
    .ped_walk(walk3), .active_dir(dir3), .phase(ph3)
  );

  logic [16:0] obs2, obs3;
  assign obs2 = {5'b0, ph2, red2, yel2, grn2, walk2, dir2};
  assign obs3 = {ph3, red3, yel3, grn3, walk3, dir3};

  typedef struct {
    int          e;
    logic [16:0] v;
    string       nm;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  int edge_n = 0;
  int n_chk = 0;
  int n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    en = 1'b1;
    night = 1'b0;
    ped = '0;
    q2.delete();
    q3.delete();
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;
    edge_n = 0;
  endtask

  task automatic exp2r(input int a, input int b,
                       input logic [2:0] ph,
                       input logic [1:0] r, input logic [1:0] y,
                       input logic [1:0] g, input logic [1:0] w,
                       input logic d, input string nm);
    for (int k = a; k <= b; k++)
      q2.push_back('{e: k, v: {5'b0, ph, r, y, g, w, d}, nm: nm});
  endtask

  task automatic exp3r(input int a, input int b,
                       input logic [2:0] ph,
                       input logic [2:0] r, input logic [2:0] y,
                       input logic [2:0] g, input logic [1:0] d,
                       input string nm);
    for (int k = a; k <= b; k++)
      q3.push_back('{e: k, v: {ph, r, y, g, 3'b000, d}, nm: nm});
  endtask

  task automatic test_reset();
    #1 nReset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (obs2 !== {5'b0, P_A, 2'b11, 6'b0, 1'b0})
      $display("FAIL reset2: got %b want %b", obs2,
               {5'b0, P_A, 2'b11, 6'b0, 1'b0});
    else n_pass++;
    n_chk++;
    if (obs3 !== {P_A, 3'b111, 9'b0, 2'b0})
      $display("FAIL reset3: got %b want %b", obs3,
               {P_A, 3'b111, 9'b0, 2'b0});
    else n_pass++;
  endtask

  task automatic test_sequence();
    exp_t x;
    do_reset();
    exp2r(1, 1, P_A, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, "allred0");
    exp2r(2, 3, P_RY, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0, "redyel0");
    exp2r(4, 11, P_G, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, "green0");
    exp2r(12, 14, P_Y, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, "yellow0");
    exp2r(15, 16, P_A, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, "allred1");
    exp2r(17, 18, P_RY, 2'b11, 2'b10, 2'b00, 2'b00, 1'b1, "redyel1");
    exp2r(19, 26, P_G, 2'b01, 2'b00, 2'b10, 2'b00, 1'b1, "green1");
    exp2r(27, 29, P_Y, 2'b01, 2'b10, 2'b00, 2'b00, 1'b1, "yellow1");
    exp2r(30, 31, P_A, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, "allred2");
    exp2r(32, 32, P_RY, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0, "wrap0");
    for (int k = 0; k < 32; k++) begin
      tick();
      while (q2.size() > 0 && q2[0].e == edge_n) begin
        x = q2.pop_front();
        n_chk++;
        if (obs2 !== x.v)
          $display("FAIL %s edge %0d: got %b want %b",
                   x.nm, edge_n, obs2, x.v);
        else n_pass++;
      end
    end
    n_chk++;
    if (q2.size() !== 0)
      $display("FAIL seq_left: got %0d pending want 0", q2.size());
    else n_pass++;
  endtask

  task automatic test_ped();
    exp_t x;
    do_reset();
    exp2r(18, 18, P_RY, 2'b11, 2'b10, 2'b00, 2'b00, 1'b1, "pre_walk");
    exp2r(19, 26, P_G, 2'b01, 2'b00, 2'b10, 2'b10, 1'b1, "walk1");
    exp2r(27, 27, P_Y, 2'b01, 2'b10, 2'b00, 2'b00, 1'b1, "walk1_off");
    exp2r(34, 41, P_G, 2'b10, 2'b00, 2'b01, 2'b01, 1'b0, "walk0_same");
    exp2r(42, 42, P_Y, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, "walk0_off");
    exp2r(49, 56, P_G, 2'b01, 2'b00, 2'b10, 2'b00, 1'b1, "walk1_clr");
    exp2r(64, 64, P_G, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, "walk0_clr");
    for (int k = 0; k < 64; k++) begin
      tick();
      if (edge_n == 6) ped = 2'b10;
      if (edge_n == 7) ped = 2'b00;
      if (edge_n == 33) ped = 2'b01;
      if (edge_n == 34) ped = 2'b00;
      while (q2.size() > 0 && q2[0].e == edge_n) begin
        x = q2.pop_front();
        n_chk++;
        if (obs2 !== x.v)
          $display("FAIL %s edge %0d: got %b want %b",
                   x.nm, edge_n, obs2, x.v);
        else n_pass++;
      end
    end
    n_chk++;
    if (q2.size() !== 0)
      $display("FAIL ped_left: got %0d pending want 0", q2.size());
    else n_pass++;
  endtask

  task automatic test_enable();
    exp_t x;
    do_reset();
    exp2r(6, 16, P_G, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, "green_frz");
    exp2r(17, 19, P_Y, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, "yel_late");
    exp2r(20, 21, P_A, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, "ar_late");
    exp2r(22, 23, P_RY, 2'b11, 2'b10, 2'b00, 2'b00, 1'b1, "ry_late");
    exp2r(24, 24, P_G, 2'b01, 2'b00, 2'b10, 2'b10, 1'b1, "walk_en0");
    for (int k = 0; k < 24; k++) begin
      tick();
      if (edge_n == 6) en = 1'b0;
      if (edge_n == 8) ped = 2'b10;
      if (edge_n == 9) ped = 2'b00;
      if (edge_n == 11) en = 1'b1;
      while (q2.size() > 0 && q2[0].e == edge_n) begin
        x = q2.pop_front();
        n_chk++;
        if (obs2 !== x.v)
          $display("FAIL %s edge %0d: got %b want %b",
                   x.nm, edge_n, obs2, x.v);
        else n_pass++;
      end
    end
    n_chk++;
    if (q2.size() !== 0)
      $display("FAIL en_left: got %0d pending want 0", q2.size());
    else n_pass++;
  endtask

  task automatic test_night();
    exp_t x;
    do_reset();
    exp2r(12, 14, P_Y, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, "n_yellow");
    exp2r(15, 16, P_A, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, "n_allred");
    exp2r(17, 20, P_N, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, "night_on");
    exp2r(21, 24, P_N, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "night_off");
    exp2r(25, 26, P_N, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, "night_on2");
    exp2r(27, 28, P_A, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, "n_exit");
    exp2r(29, 30, P_RY, 2'b11, 2'b10, 2'b00, 2'b00, 1'b1, "n_ry1");
    exp2r(31, 31, P_G, 2'b01, 2'b00, 2'b10, 2'b00, 1'b1, "n_g1");
    exp2r(46, 46, P_G, 2'b10, 2'b00, 2'b01, 2'b01, 1'b0, "n_pend");
    for (int k = 0; k < 46; k++) begin
      tick();
      if (edge_n == 5) night = 1'b1;
      if (edge_n == 21) ped = 2'b01;
      if (edge_n == 22) ped = 2'b00;
      if (edge_n == 26) night = 1'b0;
      while (q2.size() > 0 && q2[0].e == edge_n) begin
        x = q2.pop_front();
        n_chk++;
        if (obs2 !== x.v)
          $display("FAIL %s edge %0d: got %b want %b",
                   x.nm, edge_n, obs2, x.v);
        else n_pass++;
      end
    end
    n_chk++;
    if (q2.size() !== 0)
      $display("FAIL night_left: got %0d pending want 0", q2.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    exp_t x;
    do_reset();
    exp2r(13, 13, P_Y, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, "pre_rst");
    for (int k = 0; k < 13; k++) begin
      tick();
      if (edge_n == 6) ped = 2'b10;
      if (edge_n == 7) ped = 2'b00;
      while (q2.size() > 0 && q2[0].e == edge_n) begin
        x = q2.pop_front();
        n_chk++;
        if (obs2 !== x.v)
          $display("FAIL %s edge %0d: got %b want %b",
                   x.nm, edge_n, obs2, x.v);
        else n_pass++;
      end
    end
    nReset = 1'b0;
    #1;
    n_chk++;
    if (obs2 !== {5'b0, P_A, 2'b11, 6'b0, 1'b0})
      $display("FAIL async_rst: got %b want %b", obs2,
               {5'b0, P_A, 2'b11, 6'b0, 1'b0});
    else n_pass++;
    do_reset();
    exp2r(1, 1, P_A, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, "rs_allred");
    exp2r(2, 2, P_RY, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0, "rs_ry");
    exp2r(4, 4, P_G, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, "rs_g0");
    exp2r(19, 19, P_G, 2'b01, 2'b00, 2'b10, 2'b00, 1'b1, "rs_nowalk");
    for (int k = 0; k < 19; k++) begin
      tick();
      while (q2.size() > 0 && q2[0].e == edge_n) begin
        x = q2.pop_front();
        n_chk++;
        if (obs2 !== x.v)
          $display("FAIL %s edge %0d: got %b want %b",
                   x.nm, edge_n, obs2, x.v);
        else n_pass++;
      end
    end
    n_chk++;
    if (q2.size() !== 0)
      $display("FAIL rst_left: got %0d pending want 0", q2.size());
    else n_pass++;
  endtask

  task automatic test_three();
    exp_t x;
    do_reset();
    exp3r(1, 1, P_A, 3'b111, 3'b000, 3'b000, 2'd0, "t_ar0");
    exp3r(2, 3, P_RY, 3'b111, 3'b001, 3'b000, 2'd0, "t_ry0");
    exp3r(4, 4, P_G, 3'b110, 3'b000, 3'b001, 2'd0, "t_g0");
    exp3r(5, 7, P_Y, 3'b110, 3'b001, 3'b000, 2'd0, "t_y0");
    exp3r(8, 9, P_A, 3'b111, 3'b000, 3'b000, 2'd0, "t_ar1");
    exp3r(10, 11, P_RY, 3'b111, 3'b010, 3'b000, 2'd1, "t_ry1");
    exp3r(12, 12, P_G, 3'b101, 3'b000, 3'b010, 2'd1, "t_g1");
    exp3r(13, 15, P_Y, 3'b101, 3'b010, 3'b000, 2'd1, "t_y1");
    exp3r(16, 17, P_A, 3'b111, 3'b000, 3'b000, 2'd1, "t_ar2");
    exp3r(18, 19, P_RY, 3'b111, 3'b100, 3'b000, 2'd2, "t_ry2");
    exp3r(20, 20, P_G, 3'b011, 3'b000, 3'b100, 2'd2, "t_g2");
    exp3r(21, 23, P_Y, 3'b011, 3'b100, 3'b000, 2'd2, "t_y2");
    exp3r(24, 25, P_A, 3'b111, 3'b000, 3'b000, 2'd2, "t_ar3");
    exp3r(26, 27, P_RY, 3'b111, 3'b001, 3'b000, 2'd0, "t_wrap");
    exp3r(28, 28, P_G, 3'b110, 3'b000, 3'b001, 2'd0, "t_g0b");
    for (int k = 0; k < 28; k++) begin
      tick();
      n_chk++;
      if ($countones(~red3) > 1)
        $display("FAIL one_nonred edge %0d: got red %b want <=1 off",
                 edge_n, red3);
      else n_pass++;
      while (q3.size() > 0 && q3[0].e == edge_n) begin
        x = q3.pop_front();
        n_chk++;
        if (obs3 !== x.v)
          $display("FAIL %s edge %0d: got %b want %b",
                   x.nm, edge_n, obs3, x.v);
        else n_pass++;
      end
    end
    n_chk++;
    if (q3.size() !== 0)
      $display("FAIL three_left: got %0d pending want 0", q3.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_ped();
    test_enable();
    test_night();
    test_reset_mid();
    test_three();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
